// File: rtl/sel_stream_pkg.sv
// Shared constants, operand pair type and the sign-compare/select function.
package sel_stream_pkg;

    localparam int unsigned X_W      = 6;
    localparam int unsigned O_W      = 3;
    localparam int unsigned SIGN_BIT = 5;
    localparam int unsigned XSEL_HI  = 5;
    localparam int unsigned XSEL_LO  = 3;
    localparam int unsigned YSEL_HI  = 2;
    localparam int unsigned YSEL_LO  = 0;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [X_W-1:0] y;
    } pair_t;

    typedef struct packed {
        logic           path;  // 1 = x path (signs equal)
        logic [O_W-1:0] o;
    } result_t;

    function automatic result_t sel_result(pair_t p);
        result_t r;
        if (p.x[SIGN_BIT] == p.y[SIGN_BIT]) begin
            r.path = 1'b1;
            r.o    = ~p.x[XSEL_HI:XSEL_LO];
        end else begin
            r.path = 1'b0;
            r.o    = ~p.y[YSEL_HI:YSEL_LO];
        end
        return r;
    endfunction

endpackage

// File: rtl/sel_stream_ctrl_if.sv
// Operand input stream and result output stream of the select scheduler.
interface sel_stream_ctrl_if;
    import sel_stream_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [X_W-1:0] in_x;
    logic [X_W-1:0] in_y;
    logic           out_valid;
    logic           out_ready;
    logic [O_W-1:0] out_o;
    logic           out_path;

    // Scheduler side
    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_o, out_path
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_o, out_path
    );

endinterface

// File: rtl/sel_fifo.sv
// DEPTH-entry synchronous FIFO; occupancy tracked by an explicit count so the
// naturally wrapping pointers never have to disambiguate full from empty.
module sel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next-state for pointers and count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sel_stream_ctrl.sv
// Streaming scheduler: operand FIFO -> select function -> registered output
// stage with backpressure, plus saturating per-path usage counters.
module sel_stream_ctrl
    import sel_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sel_stream_ctrl_if.slave   stream,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   x_cnt,
    output logic [CNT_W-1:0]   y_cnt,
    output logic               busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pair_t          head;
    result_t        head_res;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           load, hs;

    logic           out_valid_q, out_valid_d;
    logic [O_W-1:0] out_o_q, out_o_d;
    logic           out_path_q, out_path_d;
    logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0] y_cnt_q, y_cnt_d;

    sel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * X_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (stream.in_valid),
        .pop_i   (load),
        .wdata_i ({stream.in_x, stream.in_y}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_res = sel_result(head);
    // Pop whenever the output slot is free or being drained this edge.
    assign load     = !fifo_empty && (!out_valid_q || stream.out_ready);
    assign hs       = out_valid_q && stream.out_ready;

    // Output stage next-state: load from head, else drop valid on handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_o_d     = out_o_q;
        out_path_d  = out_path_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_o_d     = head_res.o;
            out_path_d  = head_res.path;
        end else if (hs) begin
            out_valid_d = 1'b0;
        end
    end

    // Counter next-state: clear wins over a same-cycle increment; saturate.
    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (clr_cnt) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
        end else if (hs) begin
            if (out_path_q) begin
                if (x_cnt_q != '1) x_cnt_d = x_cnt_q + CNT_W'(1);
            end else begin
                if (y_cnt_q != '1) y_cnt_d = y_cnt_q + CNT_W'(1);
            end
        end
    end

    // Output stage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_o_q     <= '0;
            out_path_q  <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_o_q     <= out_o_d;
            out_path_q  <= out_path_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
        end
    end

    assign stream.in_ready  = !fifo_full;
    assign stream.out_valid = out_valid_q;
    assign stream.out_o     = out_o_q;
    assign stream.out_path  = out_path_q;
    assign x_cnt            = x_cnt_q;
    assign y_cnt            = y_cnt_q;
    assign busy             = (fifo_count != '0) || out_valid_q;

endmodule

// File: tb/tb_sel_stream_ctrl.sv
// Self-checking bench for sel_stream_ctrl: directed cases plus random traffic
// scored against a queue-based reference model.
module tb_sel_stream_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sel_stream_ctrl_if bus ();
    sel_stream_ctrl_if bus2 ();

    logic       clr_cnt, clr_cnt2;
    logic [7:0] x_cnt, y_cnt;
    logic [1:0] x_cnt2, y_cnt2;
    logic       busy, busy2;

    sel_stream_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stream  (bus.slave),
        .clr_cnt (clr_cnt),
        .x_cnt   (x_cnt),
        .y_cnt   (y_cnt),
        .busy    (busy)
    );

    sel_stream_ctrl #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .stream  (bus2.slave),
        .clr_cnt (clr_cnt2),
        .x_cnt   (x_cnt2),
        .y_cnt   (y_cnt2),
        .busy    (busy2)
    );

    // Reference model: results in acceptance order, {path, o} per entry.
    logic [3:0]  exp_q [$];
    int unsigned mdl_x, mdl_y;
    int          n_checks = 0;
    int          n_errors = 0;
    int          pops = 0;

    function automatic logic [3:0] ref_res(int unsigned x, int unsigned y);
        if ((x / 32) == (y / 32)) return {1'b1, 3'(7 - x / 8)};
        return {1'b0, 3'(7 - y % 8)};
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the main DUT with scoreboarding of both handshakes.
    task automatic tick();
        logic       push, pop, clr;
        logic [3:0] r, head;
        push = bus.in_valid && bus.in_ready;
        pop  = bus.out_valid && bus.out_ready;
        clr  = clr_cnt;
        r    = ref_res(32'(bus.in_x), 32'(bus.in_y));
        head = 4'h0;
        check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
        if (bus.out_valid) begin
            check_eq("out_valid_has_item", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check_eq("out_o", 32'(bus.out_o), 32'(head[2:0]));
                check_eq("out_path", 32'(bus.out_path), 32'(head[3]));
            end
        end
        @(posedge clk);
        #1;
        if (pop && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            pops++;
            if (!clr) begin
                if (head[3]) begin
                    if (mdl_x < 255) mdl_x++;
                end else begin
                    if (mdl_y < 255) mdl_y++;
                end
            end
        end
        if (clr) begin
            mdl_x = 0;
            mdl_y = 0;
        end
        if (push) exp_q.push_back(r);
        check_eq("x_cnt", 32'(x_cnt), mdl_x);
        check_eq("y_cnt", 32'(y_cnt), mdl_y);
    endtask

    task automatic tick2();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check_eq("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic check_reset_values(string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
        check_eq({tag, "_out_o"}, 32'(bus.out_o), 32'(0));
        check_eq({tag, "_out_path"}, 32'(bus.out_path), 32'(0));
        check_eq({tag, "_x_cnt"}, 32'(x_cnt), 32'(0));
        check_eq({tag, "_y_cnt"}, 32'(y_cnt), 32'(0));
        check_eq({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    int acc;
    int p0;
    int base;

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.in_y       = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_x      = '0;
        bus2.in_y      = '0;
        bus2.out_ready = 1'b0;
        clr_cnt        = 1'b0;
        clr_cnt2       = 1'b0;
        mdl_x          = 0;
        mdl_y          = 0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Equal signs: o = ~x[5:3] = 3'b010, x path
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 6'b101100;
        bus.in_y      = 6'b110011;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_eq("eq_out_valid", 32'(bus.out_valid), 32'(1));
        check_eq("eq_out_o", 32'(bus.out_o), 32'(3'b010));
        check_eq("eq_out_path", 32'(bus.out_path), 32'(1));
        tick();
        check_eq("eq_x_cnt", 32'(x_cnt), 32'(1));

        // Unequal signs: o = ~y[2:0] = 3'b001, y path
        bus.in_valid = 1'b1;
        bus.in_x     = 6'b011000;
        bus.in_y     = 6'b100110;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check_eq("ne_out_o", 32'(bus.out_o), 32'(3'b001));
        check_eq("ne_out_path", 32'(bus.out_path), 32'(0));
        tick();
        check_eq("ne_y_cnt", 32'(y_cnt), 32'(1));

        // Backpressure: 4 in FIFO + 1 in output register
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_x = 6'($urandom);
            bus.in_y = 6'($urandom);
            if (bus.in_ready) acc++;
            tick();
        end
        check_eq("full_accepted", 32'(acc), 32'(5));
        check_eq("full_in_ready", 32'(bus.in_ready), 32'(0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("full_drain_valid", 32'(bus.out_valid), 32'(1));
            tick();
        end
        check_eq("full_drain_busy", 32'(busy), 32'(0));

        // Streaming: 50 back-to-back pairs, one result per cycle
        base = int'(mdl_x + mdl_y);
        p0   = pops;
        for (int i = 0; i < 52; i++) begin
            if (i < 50) begin
                bus.in_valid = 1'b1;
                {bus.in_x, bus.in_y} = 12'(i);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (i >= 2) check_eq("stream_cont", 32'(bus.out_valid), 32'(1));
            tick();
        end
        check_eq("stream_results", 32'(pops - p0), 32'(50));
        check_eq("stream_cnt_sum", 32'(int'(x_cnt) + int'(y_cnt) - base), 32'(50));

        // Random traffic with backpressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_x      = 6'($urandom);
            bus.in_y      = 6'($urandom);
            bus.out_ready = ($urandom % 4) != 0;
            clr_cnt       = ($urandom % 25) == 0;
            tick();
        end
        clr_cnt = 1'b0;
        drain();

        // Saturation at 2^CNT_W-1 and clear winning over an increment
        bus2.out_ready = 1'b1;
        bus2.in_x      = 6'h00;
        bus2.in_y      = 6'h00;
        bus2.in_valid  = 1'b1;
        repeat (5) tick2();
        bus2.in_valid = 1'b0;
        repeat (3) tick2();
        check_eq("sat_x_cnt", 32'(x_cnt2), 32'(3));
        check_eq("sat_y_cnt", 32'(y_cnt2), 32'(0));
        bus2.in_y     = 6'h20;
        bus2.in_valid = 1'b1;
        tick2();
        bus2.in_valid = 1'b0;
        repeat (2) tick2();
        check_eq("sat_y_one", 32'(y_cnt2), 32'(1));
        bus2.out_ready = 1'b0;
        bus2.in_y      = 6'h00;
        bus2.in_valid  = 1'b1;
        tick2();
        bus2.in_valid = 1'b0;
        tick2();
        check_eq("clr_pre_valid", 32'(bus2.out_valid), 32'(1));
        bus2.out_ready = 1'b1;
        clr_cnt2       = 1'b1;
        tick2();
        clr_cnt2 = 1'b0;
        check_eq("clr_x_cnt", 32'(x_cnt2), 32'(0));
        check_eq("clr_y_cnt", 32'(y_cnt2), 32'(0));
        check_eq("clr_out_valid", 32'(bus2.out_valid), 32'(0));

        // Asynchronous reset mid-stream: 3 buffered + 1 in output register
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_x = 6'($urandom);
            bus.in_y = 6'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        check_eq("pre_reset_valid", 32'(bus.out_valid), 32'(1));
        check_eq("pre_reset_queued", 32'(exp_q.size()), 32'(4));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        mdl_x = 0;
        mdl_y = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_reset_in_ready", 32'(bus.in_ready), 32'(1));
        check_eq("post_reset_busy", 32'(busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
